// File: rtl/mp3_key_ctrl_if.sv
// mp3_key_ctrl_if: front-panel bundle between the raw buttons / display / audio
// path (master side) and the key controller (slave side).
// Handshake: none of these signals use valid/ready; buttons are free-running
// raw levels, player state is a registered level, and o_track_chg / o_vol_chg
// are single-cycle strobes that mark the cycle in which the new value appears.
// dbg_state mirrors the controller FSM state for observation only.
interface mp3_key_ctrl_if #(
  parameter int TW = 3,
  parameter int VW = 4
);
  logic          i_next;
  logic          i_pre;
  logic          i_vol_plus;
  logic          i_vol_dec;
  logic          i_play;
  logic [TW-1:0] o_track;
  logic [VW-1:0] o_volume;
  logic          o_playing;
  logic          o_hl_next;
  logic          o_hl_pre;
  logic          o_hl_vol_plus;
  logic          o_hl_vol_dec;
  logic          o_track_chg;
  logic          o_vol_chg;
  logic [1:0]    dbg_state;

  modport master (
    output i_next, i_pre, i_vol_plus, i_vol_dec, i_play,
    input  o_track, o_volume, o_playing,
    input  o_hl_next, o_hl_pre, o_hl_vol_plus, o_hl_vol_dec,
    input  o_track_chg, o_vol_chg, dbg_state
  );

  modport slave (
    input  i_next, i_pre, i_vol_plus, i_vol_dec, i_play,
    output o_track, o_volume, o_playing,
    output o_hl_next, o_hl_pre, o_hl_vol_plus, o_hl_vol_dec,
    output o_track_chg, o_vol_chg, dbg_state
  );
endinterface

// File: rtl/mp3_key_ctrl.sv
// mp3_key_ctrl: debounces the five front-panel keys, arbitrates simultaneous
// presses (next > pre > vol_plus > vol_dec > play) and owns track / volume /
// play state plus the display highlight flags.
// Optional feature macro: MP3_KEY_CTRL_AUTOREPEAT_EN adds the REPEAT state that
// re-steps the volume while a volume key stays held.
// Key bit order everywhere: 0 next, 1 pre, 2 vol_plus, 3 vol_dec, 4 play.
module mp3_key_ctrl #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 5000000,
  parameter int REP_CYCLES  = 10000000,
  parameter int NUM_TRACKS  = 8,
  parameter int VOL_MAX     = 15,
  parameter int VOL_INIT    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mp3_key_ctrl_if.slave  key_if
);

  localparam int TW = $clog2(NUM_TRACKS);
  localparam int VW = $clog2(VOL_MAX + 1);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(NUM_TRACKS - 1);
  localparam logic [VW-1:0] VMAX  = VW'(VOL_MAX);
  localparam logic [VW-1:0] VINIT = VW'(VOL_INIT);
  localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);

`ifdef MP3_KEY_CTRL_AUTOREPEAT_EN
  localparam int RW = $clog2(REP_CYCLES + 1);
  localparam logic [RW-1:0] RLAST = RW'(REP_CYCLES - 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_REPEAT = 2'd2} state_t;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1} state_t;
`endif

  state_t        state_q, state_d;
  logic [4:0]    raw;
  logic [4:0]    sync1_q, sync2_q, stable_q, stable_dly_q;
  logic [DW-1:0] deb_cnt_q [5];
  logic [4:0]    ev;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] track_q, track_d, track_nx, track_pv;
  logic [VW-1:0] vol_q, vol_d, vol_up, vol_dn;
  logic          playing_q, playing_d;
  logic [3:0]    hl_q, hl_d;
  logic          track_chg_q, track_chg_d;
  logic          vol_chg_q, vol_chg_d;

  assign raw = {key_if.i_play, key_if.i_vol_dec, key_if.i_vol_plus,
                key_if.i_pre, key_if.i_next};

  // Synchronize each key, then accept a new level after DEB_CYCLES agreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DLAST) begin
          stable_q[i]  <= ~stable_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Press events are rising edges of the debounced level; releases are ignored.
  assign ev = stable_q & ~stable_dly_q;

  // Wrapping track steps and saturating volume steps.
  always_comb begin
    track_nx = (track_q == TLAST) ? '0 : track_q + TW'(1);
    track_pv = (track_q == '0) ? TLAST : track_q - TW'(1);
    vol_up   = (vol_q == VMAX) ? vol_q : vol_q + VW'(1);
    vol_dn   = (vol_q == '0) ? vol_q : vol_q - VW'(1);
  end

  // Next-state: priority arbitration in IDLE, highlight timing in HOLD/REPEAT.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    track_d     = track_q;
    vol_d       = vol_q;
    playing_d   = playing_q;
    hl_d        = hl_q;
    track_chg_d = 1'b0;
    vol_chg_d   = 1'b0;
`ifdef MP3_KEY_CTRL_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ev[0]) begin
          track_d = track_nx; track_chg_d = 1'b1;
          hl_d = 4'b0001; state_d = S_HOLD; hold_cnt_d = '0;
        end else if (ev[1]) begin
          track_d = track_pv; track_chg_d = 1'b1;
          hl_d = 4'b0010; state_d = S_HOLD; hold_cnt_d = '0;
        end else if (ev[2]) begin
          vol_d = vol_up; vol_chg_d = (vol_q != VMAX);
          hl_d = 4'b0100; state_d = S_HOLD; hold_cnt_d = '0;
        end else if (ev[3]) begin
          vol_d = vol_dn; vol_chg_d = (vol_q != '0);
          hl_d = 4'b1000; state_d = S_HOLD; hold_cnt_d = '0;
        end else if (ev[4]) begin
          playing_d = ~playing_q;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HLAST) begin
`ifdef MP3_KEY_CTRL_AUTOREPEAT_EN
          if ((hl_q[2] && stable_q[2]) || (hl_q[3] && stable_q[3])) begin
            state_d = S_REPEAT; rep_cnt_d = '0;
          end else begin
            hl_d = 4'b0000; state_d = S_IDLE;
          end
`else
          hl_d = 4'b0000; state_d = S_IDLE;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
`ifdef MP3_KEY_CTRL_AUTOREPEAT_EN
      S_REPEAT: begin
        if ((hl_q[2] && !stable_q[2]) || (hl_q[3] && !stable_q[3])) begin
          hl_d = 4'b0000; state_d = S_IDLE;
        end else if (rep_cnt_q == RLAST) begin
          if (hl_q[2]) begin
            vol_d = vol_up; vol_chg_d = (vol_q != VMAX);
          end else begin
            vol_d = vol_dn; vol_chg_d = (vol_q != '0);
          end
          state_d = S_HOLD; hold_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
`endif
      default: begin
        hl_d = 4'b0000; state_d = S_IDLE;
      end
    endcase
  end

  // Player state, flags and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_cnt_q  <= '0;
      track_q     <= '0;
      vol_q       <= VINIT;
      playing_q   <= 1'b0;
      hl_q        <= 4'b0000;
      track_chg_q <= 1'b0;
      vol_chg_q   <= 1'b0;
`ifdef MP3_KEY_CTRL_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      track_q     <= track_d;
      vol_q       <= vol_d;
      playing_q   <= playing_d;
      hl_q        <= hl_d;
      track_chg_q <= track_chg_d;
      vol_chg_q   <= vol_chg_d;
`ifdef MP3_KEY_CTRL_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign key_if.o_track       = track_q;
  assign key_if.o_volume      = vol_q;
  assign key_if.o_playing     = playing_q;
  assign key_if.o_hl_next     = hl_q[0];
  assign key_if.o_hl_pre      = hl_q[1];
  assign key_if.o_hl_vol_plus = hl_q[2];
  assign key_if.o_hl_vol_dec  = hl_q[3];
  assign key_if.o_track_chg   = track_chg_q;
  assign key_if.o_vol_chg     = vol_chg_q;
  assign key_if.dbg_state     = state_q;

endmodule
